// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier and the non-restoring divider.
package mul_pkg;

  localparam int WIDTH = 32;

  // Cycles from an accepted start to the done pulse for a non-zero divisor.
  localparam int DivLatency = WIDTH + 3;

  typedef logic [2:0] div_state_t;

  localparam div_state_t DIV_IDLE = 3'd0;
  localparam div_state_t DIV_PREP = 3'd1;
  localparam div_state_t DIV_ITER = 3'd2;
  localparam div_state_t DIV_FIX  = 3'd3;
  localparam div_state_t DIV_DONE = 3'd4;

endpackage

// File: rtl/nr_divider_if.sv
// Request/result bundle of the divider. The master is the issuing controller
// and the slave is the divider.
interface nr_divider_if #(
  parameter int WIDTH = mul_pkg::WIDTH
) ();

  // Handshake: start is a one-cycle request that is honoured only while
  // busy_o is low. The operands and signed_i are sampled on that same edge.
  // busy_o stays high until done_o, inclusive. done_o pulses for exactly one
  // cycle, and the result registers hold until the next completed operation.
  logic             start;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             signed_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_by_zero_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start, dividend_i, divisor_i, signed_i,
    input  quotient_o, remainder_o, div_by_zero_o, busy_o, done_o
  );

  modport slave (
    input  start, dividend_i, divisor_i, signed_i,
    output quotient_o, remainder_o, div_by_zero_o, busy_o, done_o
  );

endinterface

// File: rtl/nr_divider_step.sv
// One radix-2 non-restoring step: shift the partial remainder left, then
// add or subtract the divisor magnitude.
module div_step
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d_mag,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] d_ext;

  // The sign of the pre-shift remainder selects the operation. The shifted
  // value may wrap, but the result always fits in WIDTH+1 bits.
  always_comb begin
    shifted = {p[WIDTH-1:0], q_msb};
    d_ext   = {1'b0, d_mag};
    p_next  = p[WIDTH] ? (shifted + d_ext) : (shifted - d_ext);
    q_bit   = ~p_next[WIDTH];
  end

endmodule

// File: rtl/nr_divider.sv
// Sequential radix-2 non-restoring divider with sign handling and final
// remainder correction. Signed or unsigned WIDTH-bit operands.
module nr_divider
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  nr_divider_if.slave bus,
  output div_state_t state_dbg
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic             signed_r;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d_mag;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   p_next;
  logic             q_bit;
  logic [WIDTH-1:0] p_fix;

  // The magnitude of MIN is MIN reinterpreted as unsigned, so MIN / -1 needs
  // no special case.
  always_comb begin
    sign_a = signed_r & dividend_r[WIDTH-1];
    sign_b = signed_r & divisor_r[WIDTH-1];
    mag_a  = sign_a ? -dividend_r : dividend_r;
    mag_b  = sign_b ? -divisor_r  : divisor_r;
    p_fix  = p[WIDTH] ? (p[WIDTH-1:0] + d_mag) : p[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q_msb  (q[WIDTH-1]),
    .d_mag  (d_mag),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      dividend_r  <= '0;
      divisor_r   <= '0;
      signed_r    <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      p           <= '0;
      q           <= '0;
      d_mag       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.start) begin
            dividend_r <= bus.dividend_i;
            divisor_r  <= bus.divisor_i;
            signed_r   <= bus.signed_i;
            state      <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          q_neg <= sign_a ^ sign_b;
          r_neg <= sign_a;
          p     <= '0;
          q     <= mag_a;
          d_mag <= mag_b;
          cnt   <= CntW'(WIDTH - 1);
          if (divisor_r == '0) begin
            quotient    <= '1;
            remainder   <= dividend_r;
            div_by_zero <= 1'b1;
            state       <= DIV_DONE;
          end else begin
            state <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          p <= p_next;
          q <= {q[WIDTH-2:0], q_bit};
          if (cnt == '0) begin
            state <= DIV_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV_FIX: begin
          quotient    <= q_neg ? -q : q;
          remainder   <= r_neg ? -p_fix : p_fix;
          div_by_zero <= 1'b0;
          state       <= DIV_DONE;
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient_o    = quotient;
  assign bus.remainder_o   = remainder;
  assign bus.div_by_zero_o = div_by_zero;
  assign bus.busy_o        = (state != DIV_IDLE);
  assign bus.done_o        = (state == DIV_DONE);
  assign state_dbg         = state;

endmodule

// File: doc/nr_divider.md
# nr_divider

Sequential radix-2 non-restoring integer divider producing quotient and remainder for signed or unsigned `WIDTH`-bit operands. It is the inverse-operation companion of the Booth multiplier and shares `mul_pkg` with it. It uses the same `start`/`done` convention, so one controller can issue multiply and divide operations to either unit. Sign handling and the final remainder correction are inside the block, so results can be used directly.

## Interface
Parameters:
- `WIDTH`, default `mul_pkg::WIDTH` (32): operand and result width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `dividend_i`  in  WIDTH  dividend; captured on an accepted `start`.
- `divisor_i`  in  WIDTH  divisor; captured on an accepted `start`.
- `signed_i`  in  1  1 = two's-complement operands, 0 = unsigned; captured on an accepted `start`.
- `quotient_o`  out  WIDTH  registered quotient.
- `remainder_o`  out  WIDTH  registered remainder.
- `div_by_zero_o`  out  1  set with `done_o` when the divisor is 0; held with the result.
- `busy_o`  out  1  high from the cycle after an accepted `start` until `done_o`, inclusive.
- `done_o`  out  1  one-cycle pulse when the results are valid.

## Operation
- FSM type `div_state_t` has five states: IDLE, PREP, ITER, FIX, DONE.
- **IDLE**
  - On `start`, register the operands and `signed_i`, then go to PREP.
  - `start` in any other state is ignored and is not queued.
- **PREP**
  - Form magnitudes: if signed and the MSB is set, negate the operand; otherwise pass it through.
  - Record `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend). Both are 0 when unsigned.
  - Partial remainder P (WIDTH+1 bits, signed) = 0. Q = |dividend|. Iteration counter = WIDTH−1.
  - If the divisor is 0, skip to DONE with Q = all ones, R = original dividend, and `div_by_zero` set.
- **ITER** (WIDTH cycles)
  - Shift {P,Q} left by one.
  - If P ≥ 0, P = P − |D|; otherwise P = P + |D|.
  - Q[0] = ~P[WIDTH], using the new P.
  - The counter decrements. Leave for FIX when the counter reaches 0.
- **FIX**
  - If P < 0, P = P + |D|.
  - Quotient = `q_neg` ? −Q : Q. Remainder = `r_neg` ? −P[WIDTH-1:0] : P[WIDTH-1:0].
  - Load the output registers, then go to DONE.
- **DONE**
  - Assert `done_o` for one cycle, then return to IDLE.
- Signed overflow (MIN / −1) requires no special path. It yields quotient = MIN and remainder = 0, because |MIN| is handled as unsigned 2^(WIDTH−1).
- Remainder sign always equals the dividend sign (truncating division), and |R| < |D|.
- Output registers hold the last result until the next FIX or divide-by-zero load. They are not cleared on `start`.

## Timing
- Accepted `start` at edge 0: PREP runs during cycle 1, ITER during cycles 2..WIDTH+1, FIX during cycle WIDTH+2, and `done_o` is high during cycle WIDTH+3.
- Latency from `start` to `done_o` is WIDTH+3 cycles (35 for WIDTH=32).
- Divide by zero: `done_o` is high during cycle 2.
- `busy_o` is low in IDLE only. A new `start` is accepted in the cycle after `done_o` (back-to-back with no gap).
- Reset values:
  - FSM = IDLE.
  - `quotient_o`, `remainder_o` = 0.
  - `div_by_zero_o`, `done_o`, `busy_o` = 0.
  - Internal P, Q, and counter = 0.
- Reset mid-operation aborts immediately to IDLE. No `done_o` is produced for the aborted operation.

## Structure
- Add `div_state_t` to `mul_pkg`, alongside the existing `WIDTH` constant. Also add a localparam `DivLatency` = WIDTH+3.
- One combinational sub-module, `div_step`:
  - Inputs: P, Q MSB, |D|.
  - Outputs: next P and the quotient bit.
  - It contains the WIDTH+1-bit add/subtract.
- Top level contains the FSM, the operand/sign registers, the counter, and the output registers.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, `done_o` exactly 35 cycles after `start`, `busy_o` high for cycles 1..35.
- Signed −100 / 7 → quotient −14 (0xFFFFFFF2), remainder −2 (0xFFFFFFFE). Signed 100 / −7 → quotient −14, remainder 2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 with dividend 0x1234 → `done_o` at cycle 2, quotient 0xFFFFFFFF, remainder 0x1234, `div_by_zero_o` = 1.
- `start` pulsed mid-ITER with new operands → ignored, first result unchanged. Back-to-back `start` right after `done_o` → accepted.
- `rst_n` asserted at cycle 10 of an operation → all outputs 0 and FSM in IDLE. A following request completes correctly.
